// File: rtl/demux1x16_reg.sv
// Registered 1-to-16 byte distributor: steers handshaked input bytes into 16 lane
// registers by explicit select or auto-incrementing pointer, then stalls until a frame ack.
module demux1x16_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             mode,
    input  logic [3:0]       select,
    input  logic             ack,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15,
    output logic [15:0]      lane_valid,
    output logic [3:0]       cur_lane,
    output logic             frame_done
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] lane_q [16];
    logic [15:0]      lane_valid_q, lane_valid_d;
    logic [3:0]       cur_lane_q, cur_lane_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic [3:0]       target;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid & in_ready;
    // Target lane uses the pre-ack pointer so a beat coinciding with ack still lands where it was aimed.
    assign target   = mode ? cur_lane_q : select;

    always_comb begin
        state_d      = state_q;
        lane_valid_d = lane_valid_q;
        cur_lane_d   = cur_lane_q;
        frame_done_d = 1'b0;
        if (state_q == FILL) begin
            if (ack) begin
                lane_valid_d = '0;
                cur_lane_d   = '0;
            end
            if (accept) begin
                lane_valid_d[target] = 1'b1;
                if (mode) begin
                    cur_lane_d = cur_lane_d + 4'd1;
                end
            end
            if (lane_valid_d == 16'hFFFF) begin
                state_d      = FULL;
                frame_done_d = 1'b1;
            end
        end else if (ack) begin
            lane_valid_d = '0;
            cur_lane_d   = '0;
            state_d      = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            lane_valid_q <= '0;
            cur_lane_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_valid_q <= lane_valid_d;
            cur_lane_q   <= cur_lane_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                lane_q[i] <= '0;
            end
        end else if (accept) begin
            lane_q[target] <= in_data;
        end
    end

    assign out0       = lane_q[0];
    assign out1       = lane_q[1];
    assign out2       = lane_q[2];
    assign out3       = lane_q[3];
    assign out4       = lane_q[4];
    assign out5       = lane_q[5];
    assign out6       = lane_q[6];
    assign out7       = lane_q[7];
    assign out8       = lane_q[8];
    assign out9       = lane_q[9];
    assign out10      = lane_q[10];
    assign out11      = lane_q[11];
    assign out12      = lane_q[12];
    assign out13      = lane_q[13];
    assign out14      = lane_q[14];
    assign out15      = lane_q[15];
    assign lane_valid = lane_valid_q;
    assign cur_lane   = cur_lane_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux1x16_reg.sv
// Scoreboard bench for demux1x16_reg: the driver predicts each cycle's outputs from a
// lane/flag/pointer reference model, the monitor pops and compares after every edge.
module tb_demux1x16_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         mode;
    logic [3:0]   select;
    logic         ack;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [W-1:0] out8, out9, out10, out11, out12, out13, out14, out15;
    logic [15:0]  lane_valid;
    logic [3:0]   cur_lane;
    logic         frame_done;

    demux1x16_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mode(mode), .select(select), .ack(ack),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
        .out6(out6), .out7(out7), .out8(out8), .out9(out9), .out10(out10), .out11(out11),
        .out12(out12), .out13(out13), .out14(out14), .out15(out15),
        .lane_valid(lane_valid), .cur_lane(cur_lane), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16*W-1:0] data;
        logic [15:0]     lv;
        logic [3:0]      cl;
        logic            fd;
        logic            rdy;
    } snap_t;

    snap_t q[$];
    int    vectors = 0;
    int    miscompares = 0;

    logic [W-1:0] m_mem [16];
    bit           m_flag [16];
    int           m_ptr;
    bit           m_full;

    logic [16*W-1:0] dut_flat;
    assign dut_flat = {out15, out14, out13, out12, out11, out10, out9, out8,
                       out7, out6, out5, out4, out3, out2, out1, out0};

    task automatic chk(input string name, input logic [16*W-1:0] act, input logic [16*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = '0;
            m_flag[i] = 1'b0;
        end
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    // Applies one clock edge of the reference rules and returns the predicted outputs.
    task automatic model_step(output snap_t s);
        int  lane;
        bit  all;
        bit  fd;
        fd = 1'b0;
        if (m_full) begin
            if (ack) begin
                for (int i = 0; i < 16; i++) m_flag[i] = 1'b0;
                m_ptr  = 0;
                m_full = 1'b0;
            end
        end else begin
            lane = mode ? m_ptr : int'(select);
            if (ack) begin
                for (int i = 0; i < 16; i++) m_flag[i] = 1'b0;
                m_ptr = 0;
            end
            if (in_valid) begin
                m_mem[lane]  = in_data;
                m_flag[lane] = 1'b1;
                if (mode) m_ptr = (m_ptr + 1) % 16;
            end
            all = 1'b1;
            for (int i = 0; i < 16; i++) if (!m_flag[i]) all = 1'b0;
            if (all) begin
                m_full = 1'b1;
                fd     = 1'b1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            s.data[i*W +: W] = m_mem[i];
            s.lv[i]          = m_flag[i];
        end
        s.cl  = 4'(m_ptr);
        s.fd  = fd;
        s.rdy = !m_full;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic m,
                       input logic [3:0] s, input logic a);
        snap_t e;
        in_valid = v;
        in_data  = d;
        mode     = m;
        select   = s;
        ack      = a;
        @(posedge clk);
        model_step(e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, dut_flat, '0);
        chk({tag, "_lane_valid"}, 128'(lane_valid), '0);
        chk({tag, "_cur_lane"}, 128'(cur_lane), '0);
        chk({tag, "_frame_done"}, 128'(frame_done), '0);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    always @(posedge clk) begin
        snap_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("data", dut_flat, e.data);
            chk("lane_valid", 128'(lane_valid), 128'(e.lv));
            chk("cur_lane", 128'(cur_lane), 128'(e.cl));
            chk("frame_done", 128'(frame_done), 128'(e.fd));
            chk("in_ready", 128'(in_ready), 128'(e.rdy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; in_data = '0; mode = 1'b0; select = '0; ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Auto mode fill 0x00..0x0F, then FULL stall with 0xAA offered
        for (int i = 0; i < 16; i++) cyc(1'b1, W'(i), 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hAA, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 4'd0, 1'b1);
        cyc(1'b1, 8'hAA, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 4'd0, 1'b1);

        // Addressed writes with overwrite
        cyc(1'b1, 8'h11, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 4'd9, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 4'd0, 1'b1);

        // Ack in FILL coinciding with an auto beat
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1, 4'd0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 4'd0, 1'b0);

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h70 + i), 1'b1, 4'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'hC3, 1'b1, 4'd0, 1'b0);

        // Mixed-mode completion: auto lanes up to 14, addressed lane 15
        cyc(1'b0, 8'h00, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h90 + i), 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 4'd15, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h01, 1'b0, 4'd2, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 4'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(3, 0) != 0), 8'($urandom), 1'($urandom),
                4'($urandom), ($urandom_range(15, 0) == 0));
        end

        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
